// File: rtl/ifu_pc_sequencer_pkg.sv
// Shared constants, state/redirect encodings and address helpers for the
// fetch-unit next-PC sequencer.
package ifu_pc_sequencer_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO  = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI  = 32'h0000_6FFC;
  localparam logic [31:0] PC_STEP  = 32'h0000_0004;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_DONE  = 2'b10
  } seq_state_e;

  // Encoded so that a numeric compare orders redirects by priority.
  typedef enum logic [1:0] {
    PK_NONE = 2'b00,
    PK_BR   = 2'b01,
    PK_ERET = 2'b10,
    PK_EXC  = 2'b11
  } pend_kind_e;

  function automatic logic fetch_addr_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr >= TEXT_LO) && (addr <= TEXT_HI);
  endfunction

  function automatic logic kind_kills(input pend_kind_e kind);
    return (kind == PK_ERET) || (kind == PK_EXC);
  endfunction

endpackage

// File: rtl/ifu_pc_sequencer_if.sv
// Fetch-side bundle between the next-PC sequencer and its neighbours
// (hazard unit, ID branch logic, CP0, PC register, instruction memory).
interface ifu_pc_sequencer_if;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        stall;
  logic        br_take;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic        imem_req;
  logic        imem_ready;
  logic        if_valid;
  logic        adel;

  modport master (
    input  pc_q,
    input  stall,
    input  br_take,
    input  br_target,
    input  exc_req,
    input  eret_req,
    input  epc,
    input  imem_ready,
    output pc_d,
    output imem_req,
    output if_valid,
    output adel
  );

  modport slave (
    output pc_q,
    output stall,
    output br_take,
    output br_target,
    output exc_req,
    output eret_req,
    output epc,
    output imem_ready,
    input  pc_d,
    input  imem_req,
    input  if_valid,
    input  adel
  );

endinterface

// File: rtl/ifu_redirect_buf.sv
// Pending-redirect register: captures branch/eret/exception requests every
// cycle and only lets an equal-or-higher priority request replace a held one.
module ifu_redirect_buf
  import ifu_pc_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        RESET,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        br_take,
  input  logic [31:0] br_target,
  input  logic        consume,
  output pend_kind_e  eff_kind,
  output logic [31:0] eff_target
);

  pend_kind_e  kind_q;
  pend_kind_e  kind_d;
  pend_kind_e  req_kind;
  logic [31:0] target_q;
  logic [31:0] target_d;
  logic [31:0] req_target;

  always_comb begin
    req_kind   = PK_NONE;
    req_target = 32'h0000_0000;
    if (exc_req) begin
      req_kind   = PK_EXC;
      req_target = EXC_VEC;
    end else if (eret_req) begin
      req_kind   = PK_ERET;
      req_target = epc;
    end else if (br_take) begin
      req_kind   = PK_BR;
      req_target = br_target;
    end else begin
      req_kind   = PK_NONE;
      req_target = 32'h0000_0000;
    end
  end

  // eff_* is what the sequencer may apply this very cycle: a fresh request
  // already folded into the held one.
  always_comb begin
    eff_kind   = kind_q;
    eff_target = target_q;
    if ((req_kind != PK_NONE) && (req_kind >= kind_q)) begin
      eff_kind   = req_kind;
      eff_target = req_target;
    end else begin
      eff_kind   = kind_q;
      eff_target = target_q;
    end
  end

  always_comb begin
    kind_d   = eff_kind;
    target_d = eff_target;
    if (consume) begin
      kind_d   = PK_NONE;
      target_d = target_q;
    end else begin
      kind_d   = eff_kind;
      target_d = eff_target;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      kind_q   <= PK_NONE;
      target_q <= 32'h0000_0000;
    end else begin
      kind_q   <= kind_d;
      target_q <= target_d;
    end
  end

endmodule

// File: rtl/ifu_pc_sequencer.sv
// Next-PC controller for the fetch unit: drives the PC register D input and
// runs the instruction-memory request/ready handshake.
module ifu_pc_sequencer
  import ifu_pc_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               RESET,
  ifu_pc_sequencer_if.master bus
);

  seq_state_e  state_q;
  seq_state_e  state_d;
  pend_kind_e  eff_kind;
  logic [31:0] eff_target;
  logic        consume;
  logic        addr_ok;
  logic        kill;
  logic        complete;
  logic [31:0] accept_pc;
  logic [31:0] pc_nxt;
  logic        req_nxt;
  logic        valid_nxt;
  logic        adel_nxt;

  ifu_redirect_buf u_redirect_buf (
    .clk        (clk),
    .RESET      (RESET),
    .exc_req    (bus.exc_req),
    .eret_req   (bus.eret_req),
    .epc        (bus.epc),
    .br_take    (bus.br_take),
    .br_target  (bus.br_target),
    .consume    (consume),
    .eff_kind   (eff_kind),
    .eff_target (eff_target)
  );

  // A branch is only a deferred target; eret/exception also flush the slot.
  always_comb begin
    addr_ok   = fetch_addr_legal(bus.pc_q);
    kill      = kind_kills(eff_kind);
    accept_pc = (eff_kind != PK_NONE) ? eff_target : (bus.pc_q + PC_STEP);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_nxt    = bus.pc_q;
    req_nxt   = 1'b0;
    valid_nxt = 1'b0;
    adel_nxt  = 1'b0;
    consume   = 1'b0;
    complete  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        req_nxt  = addr_ok;
        complete = addr_ok ? bus.imem_ready : 1'b1;
        if (complete && kill) begin
          pc_nxt  = eff_target;
          consume = 1'b1;
          state_d = ST_FETCH;
        end else if (complete && !bus.stall) begin
          valid_nxt = 1'b1;
          adel_nxt  = !addr_ok;
          pc_nxt    = accept_pc;
          consume   = 1'b1;
          state_d   = ST_FETCH;
        end else if (complete) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        complete = 1'b1;
        if (kill) begin
          pc_nxt  = eff_target;
          consume = 1'b1;
          state_d = ST_FETCH;
        end else if (!bus.stall) begin
          valid_nxt = 1'b1;
          adel_nxt  = !addr_ok;
          pc_nxt    = accept_pc;
          consume   = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
    // Reset dominates whatever the state machine decided this cycle.
    if (RESET) begin
      pc_nxt    = RESET_PC;
      req_nxt   = 1'b0;
      valid_nxt = 1'b0;
      adel_nxt  = 1'b0;
      consume   = 1'b0;
      state_d   = ST_BOOT;
    end else begin
      state_d = state_d;
    end
  end

  assign bus.pc_d     = pc_nxt;
  assign bus.imem_req = req_nxt;
  assign bus.if_valid = valid_nxt;
  assign bus.adel     = adel_nxt;

endmodule

// File: tb/tb_ifu_pc_sequencer.sv
// Directed bench for ifu_pc_sequencer: an in-bench behavioural model checks
// every cycle, and hand-computed literals pin the main scenarios.
module tb_ifu_pc_sequencer;

  localparam logic [31:0] M_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] M_EXC_VEC  = 32'h0000_4180;
  localparam logic [31:0] M_TEXT_LO  = 32'h0000_3000;
  localparam logic [31:0] M_TEXT_HI  = 32'h0000_6FFC;

  logic clk = 1'b0;
  logic RESET;
  logic pc_ovr;
  logic [31:0] pc_ovr_val;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ifu_pc_sequencer_if bus();

  ifu_pc_sequencer dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  // Bench-side PC register, with an override to plant arbitrary addresses.
  always @(posedge clk) begin
    if (RESET) bus.pc_q <= M_RESET_PC;
    else if (pc_ovr) bus.pc_q <= pc_ovr_val;
    else bus.pc_q <= bus.pc_d;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
  endtask

  // Model: "booted", "instruction in hand" and a ranked pending redirect.
  initial begin
    bit m_boot, m_held, ok, have;
    int m_rank, rq_rank, r_rank;
    logic [31:0] m_tgt, rq_tgt, r_tgt, e_pc;
    logic e_req, e_val, e_adel;
    m_boot = 1'b1; m_held = 1'b0; m_rank = 0; m_tgt = 32'h0;
    forever begin
      @(negedge clk);
      e_pc = bus.pc_q; e_req = 1'b0; e_val = 1'b0; e_adel = 1'b0;
      if (RESET) begin
        e_pc = M_RESET_PC;
        m_boot = 1'b1; m_held = 1'b0; m_rank = 0;
      end else begin
        if (bus.exc_req) begin rq_rank = 3; rq_tgt = M_EXC_VEC; end
        else if (bus.eret_req) begin rq_rank = 2; rq_tgt = bus.epc; end
        else if (bus.br_take) begin rq_rank = 1; rq_tgt = bus.br_target; end
        else begin rq_rank = 0; rq_tgt = 32'h0; end
        if (rq_rank != 0 && rq_rank >= m_rank) begin r_rank = rq_rank; r_tgt = rq_tgt; end
        else begin r_rank = m_rank; r_tgt = m_tgt; end
        if (m_boot) begin
          m_boot = 1'b0; m_rank = r_rank; m_tgt = r_tgt;
        end else begin
          ok = (bus.pc_q[1:0] == 2'b00) && (bus.pc_q >= M_TEXT_LO) && (bus.pc_q <= M_TEXT_HI);
          have = m_held || !ok || bus.imem_ready;
          e_req = !m_held && ok;
          if (have && r_rank >= 2) begin
            e_pc = r_tgt; m_rank = 0; m_held = 1'b0;
          end else if (have && !bus.stall) begin
            e_val = 1'b1; e_adel = !ok;
            e_pc = (r_rank != 0) ? r_tgt : bus.pc_q + 32'd4;
            m_rank = 0; m_held = 1'b0;
          end else begin
            m_held = have; m_rank = r_rank; m_tgt = r_tgt;
          end
        end
      end
      chk("model pc_d", bus.pc_d, e_pc);
      chk1("model imem_req", bus.imem_req, e_req);
      chk1("model if_valid", bus.if_valid, e_val);
      chk1("model adel", bus.adel, e_adel);
    end
  end

  // Drive one cycle's inputs just after posedge, return at the following negedge.
  task automatic cyc(input bit rst, input bit st, input bit rdy, input bit br,
                     input logic [31:0] bt, input bit ex, input bit er, input logic [31:0] ep);
    @(posedge clk);
    #1;
    pc_ovr = 1'b0;
    RESET = rst; bus.stall = st; bus.imem_ready = rdy;
    bus.br_take = br; bus.br_target = bt;
    bus.exc_req = ex; bus.eret_req = er; bus.epc = ep;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [31:0] pc, input logic val);
    chk({name, " pc_d"}, bus.pc_d, pc);
    chk1({name, " if_valid"}, bus.if_valid, val);
  endtask

  initial begin
    RESET = 1'b1; pc_ovr = 1'b0; pc_ovr_val = 32'h0;
    bus.stall = 1'b0; bus.imem_ready = 1'b1; bus.br_take = 1'b0; bus.br_target = 32'h0;
    bus.exc_req = 1'b0; bus.eret_req = 1'b0; bus.epc = 32'h0;

    cyc(1, 0, 1, 0, 0, 0, 0, 0); lit("reset", 32'h3000, 1'b0);
    chk1("reset imem_req", bus.imem_req, 1'b0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0); lit("boot", 32'h3000, 1'b0);
    chk1("boot imem_req", bus.imem_req, 1'b0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0); lit("seq1", 32'h3004, 1'b1);
    cyc(0, 0, 1, 0, 0, 0, 0, 0); lit("seq2", 32'h3008, 1'b1);

    // stall at pc_q=0x3008
    cyc(0, 1, 1, 0, 0, 0, 0, 0); lit("stall1", 32'h3008, 1'b0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0); lit("stall2", 32'h3008, 1'b0);
    chk1("stall2 imem_req", bus.imem_req, 1'b0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0); lit("stall3", 32'h3008, 1'b0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0); lit("unstall", 32'h300C, 1'b1);
    cyc(0, 0, 1, 0, 0, 0, 0, 0); lit("seq4", 32'h3010, 1'b1);

    // branch with delay slot at 0x3010, memory slow for two cycles
    cyc(0, 0, 0, 1, 32'h3100, 0, 0, 0); lit("br wait1", 32'h3010, 1'b0);
    chk1("br wait1 imem_req", bus.imem_req, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0); lit("br wait2", 32'h3010, 1'b0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0); lit("br slot", 32'h3100, 1'b1);
    cyc(0, 0, 1, 0, 0, 0, 0, 0); lit("br tgt", 32'h3104, 1'b1);

    // branch while stalled, exception one cycle later
    cyc(0, 1, 1, 1, 32'h3200, 0, 0, 0); lit("stall br", 32'h3104, 1'b0);
    cyc(0, 1, 1, 0, 0, 1, 0, 0); lit("exc kill", 32'h4180, 1'b0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0); lit("exc vec", 32'h4184, 1'b1);

    // eret together with branch, in-flight fetch killed
    cyc(0, 0, 0, 1, 32'h3200, 0, 1, 32'h3040); lit("eret wait", 32'h4184, 1'b0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0); lit("eret kill", 32'h3040, 1'b0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0); lit("eret tgt", 32'h3044, 1'b1);

    // illegal addresses: misaligned, above range, then exception
    pc_ovr_val = 32'h3002; pc_ovr = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0); lit("misalign", 32'h3006, 1'b1);
    chk1("misalign adel", bus.adel, 1'b1);
    chk1("misalign imem_req", bus.imem_req, 1'b0);
    pc_ovr_val = 32'h7000; pc_ovr = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0); lit("oor", 32'h7004, 1'b1);
    chk1("oor adel", bus.adel, 1'b1);
    chk1("oor imem_req", bus.imem_req, 1'b0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0); lit("adel exc", 32'h4180, 1'b0);
    chk1("adel exc adel", bus.adel, 1'b0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0); lit("after exc", 32'h4184, 1'b1);

    // range edges: TEXT_HI legal, just below TEXT_LO illegal
    pc_ovr_val = 32'h6FFC; pc_ovr = 1'b1;
    cyc(0, 0, 1, 0, 0, 0, 0, 0); lit("hi edge", 32'h7000, 1'b1);
    chk1("hi edge adel", bus.adel, 1'b0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    pc_ovr_val = 32'h2FFC; pc_ovr = 1'b1;
    cyc(0, 0, 1, 0, 0, 0, 0, 0); lit("lo edge", 32'h3000, 1'b1);
    chk1("lo edge adel", bus.adel, 1'b1);

    // pending eret is not displaced by a later branch
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h3080);
    cyc(0, 0, 0, 1, 32'h3300, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0); lit("eret keep", 32'h3080, 1'b0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0); lit("eret keep2", 32'h3084, 1'b1);

    // reset mid-fetch with a branch pending
    cyc(0, 0, 0, 1, 32'h3300, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0); lit("midrst", 32'h3000, 1'b0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0); lit("midrst boot", 32'h3000, 1'b0);
    chk1("midrst boot imem_req", bus.imem_req, 1'b0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0); lit("midrst clear", 32'h3004, 1'b1);

    // mixed pattern, model-checked
    for (int i = 0; i < 24; i++) begin
      cyc(0, (i % 5) == 2, (i % 3) != 1, (i % 7) == 3, 32'h3400 + (32'(i) << 4),
          i == 11, i == 17, 32'h3500);
    end
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
